// File: rtl/ddr3_cmd_scheduler_if.sv
// Host-side request/response bundle for the DDR3 command scheduler.
// The host drives a single read/write request; the scheduler accepts it on
// req_valid && req_ready and pulses rsp_done when the burst has completed.
interface ddr3_cmd_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [14:0] req_row;
    logic [9:0]  req_col;
    logic [15:0] req_wdata;
    logic        rsp_done;

    modport master (
        output req_valid, req_write, req_row, req_col, req_wdata,
        input  req_ready, rsp_done
    );

    modport slave (
        input  req_valid, req_write, req_row, req_col, req_wdata,
        output req_ready, rsp_done
    );
endinterface

// File: rtl/ddr3_cmd_scheduler.sv
// DDR3 command scheduler: runs the ZQCL/MRS power-up sequence, then services
// single host requests with PRE/ACT/READ/WRITE strobes under an open-page
// policy, inserting a periodic refresh. Strobes are decoded from the
// registered state, so at most one of them is ever high.
module ddr3_cmd_scheduler #(
    parameter int T_INIT  = 2,
    parameter int T_ZQ    = 4,
    parameter int T_MRD   = 4,
    parameter int T_RP    = 3,
    parameter int T_RCD   = 3,
    parameter int T_BURST = 4,
    parameter int T_RFC   = 10,
    parameter int T_REFI  = 200
) (
    input  logic                 CLK,
    input  logic                 RESET,
    ddr3_cmd_scheduler_if.slave  host,
    output logic                 ZQCL,
    output logic                 MRS,
    output logic                 REF,
    output logic                 PRE,
    output logic                 ACT,
    output logic                 READ,
    output logic                 WRITE,
    output logic [14:0]          Addr_Row,
    output logic [9:0]           Addr_Column,
    output logic                 A_10,
    output logic [15:0]          DQ_out,
    output logic                 init_done,
    output logic                 row_open,
    output logic [14:0]          open_row
);
    localparam int CNT_W  = 16;
    localparam int REFI_W = $clog2(T_REFI + 1);

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_ZQ, S_ZQ_WAIT, S_MRS, S_MRS_WAIT, S_IDLE,
        S_PRE, S_PRE_WAIT, S_REF, S_REF_WAIT, S_ACT, S_ACT_WAIT,
        S_RW, S_RW_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REFI_W-1:0]  refi_q, refi_d;
    logic               ref_pending_q, ref_pending_d;
    logic               ref_svc_q, ref_svc_d;
    logic               init_done_q, init_done_d;
    logic               row_open_q, row_open_d;
    logic [14:0]        open_row_q, open_row_d;
    logic [14:0]        addr_row_q, addr_row_d;
    logic [9:0]         addr_col_q, addr_col_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               wr_flag_q, wr_flag_d;
    logic               rsp_done_q, rsp_done_d;
    logic               refi_wrap;

    // True on the final cycle of a wait that lasts len cycles (cnt starts at 0).
    function automatic logic wait_last(input logic [CNT_W-1:0] cnt, input int len);
        return cnt == CNT_W'(len - 1);
    endfunction

    // Refresh interval timer; at most one refresh is held pending.
    always_comb begin
        refi_d        = refi_q;
        ref_pending_d = ref_pending_q;
        refi_wrap     = init_done_q && (refi_q == REFI_W'(T_REFI - 1));
        if (init_done_q) begin
            refi_d = refi_wrap ? '0 : refi_q + 1'b1;
        end
        if (state_q == S_REF) begin
            ref_pending_d = 1'b0;
        end
        if (refi_wrap) begin
            ref_pending_d = 1'b1;
        end
    end

    // Next-state logic, wait counting and request/row bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        ref_svc_d   = ref_svc_q;
        init_done_d = init_done_q;
        row_open_d  = row_open_q;
        open_row_d  = open_row_q;
        addr_row_d  = addr_row_q;
        addr_col_d  = addr_col_q;
        wdata_d     = wdata_q;
        wr_flag_d   = wr_flag_q;
        rsp_done_d  = 1'b0;

        case (state_q)
            S_INIT_WAIT: begin
                if (wait_last(cnt_q, T_INIT)) state_d = S_ZQ;
                else                          cnt_d   = cnt_q + 1'b1;
            end
            S_ZQ: begin
                if (T_ZQ > 1) state_d = S_ZQ_WAIT;
                else          state_d = S_MRS;
            end
            S_ZQ_WAIT: begin
                if (wait_last(cnt_q, T_ZQ - 1)) state_d = S_MRS;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            S_MRS: begin
                if (T_MRD > 1) begin
                    state_d = S_MRS_WAIT;
                end else begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_MRS_WAIT: begin
                if (wait_last(cnt_q, T_MRD - 1)) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                // A pending refresh always wins over a waiting request.
                if (ref_pending_q) begin
                    ref_svc_d = 1'b1;
                    if (row_open_q) state_d = S_PRE;
                    else            state_d = S_REF;
                end else if (host.req_valid) begin
                    ref_svc_d  = 1'b0;
                    addr_row_d = host.req_row;
                    addr_col_d = host.req_col;
                    wdata_d    = host.req_wdata;
                    wr_flag_d  = host.req_write;
                    if (row_open_q && (open_row_q == host.req_row)) state_d = S_RW;
                    else if (row_open_q)                            state_d = S_PRE;
                    else                                            state_d = S_ACT;
                end
            end
            S_PRE: begin
                if (T_RP > 1)       state_d = S_PRE_WAIT;
                else if (ref_svc_q) state_d = S_REF;
                else                state_d = S_ACT;
            end
            S_PRE_WAIT: begin
                // The same precharge path serves both refresh and row misses.
                if (wait_last(cnt_q, T_RP - 1)) begin
                    if (ref_svc_q) state_d = S_REF;
                    else           state_d = S_ACT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REF: begin
                row_open_d = 1'b0;
                ref_svc_d  = 1'b0;
                if (T_RFC > 1) state_d = S_REF_WAIT;
                else           state_d = S_IDLE;
            end
            S_REF_WAIT: begin
                if (wait_last(cnt_q, T_RFC - 1)) state_d = S_IDLE;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            S_ACT: begin
                row_open_d = 1'b1;
                open_row_d = addr_row_q;
                if (T_RCD > 1) state_d = S_ACT_WAIT;
                else           state_d = S_RW;
            end
            S_ACT_WAIT: begin
                if (wait_last(cnt_q, T_RCD - 1)) state_d = S_RW;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            S_RW: begin
                if (T_BURST > 1) begin
                    state_d = S_RW_WAIT;
                end else begin
                    state_d    = S_IDLE;
                    rsp_done_d = 1'b1;
                end
            end
            S_RW_WAIT: begin
                // rsp_done is registered, so it shows T_BURST cycles after RW.
                if (wait_last(cnt_q, T_BURST - 1)) begin
                    state_d    = S_IDLE;
                    rsp_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_INIT_WAIT;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_INIT_WAIT;
            cnt_q         <= '0;
            refi_q        <= '0;
            ref_pending_q <= 1'b0;
            ref_svc_q     <= 1'b0;
            init_done_q   <= 1'b0;
            row_open_q    <= 1'b0;
            open_row_q    <= '0;
            addr_row_q    <= '0;
            addr_col_q    <= '0;
            wdata_q       <= '0;
            wr_flag_q     <= 1'b0;
            rsp_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            refi_q        <= refi_d;
            ref_pending_q <= ref_pending_d;
            ref_svc_q     <= ref_svc_d;
            init_done_q   <= init_done_d;
            row_open_q    <= row_open_d;
            open_row_q    <= open_row_d;
            addr_row_q    <= addr_row_d;
            addr_col_q    <= addr_col_d;
            wdata_q       <= wdata_d;
            wr_flag_q     <= wr_flag_d;
            rsp_done_q    <= rsp_done_d;
        end
    end

    assign host.req_ready = (state_q == S_IDLE) && !ref_pending_q;
    assign host.rsp_done  = rsp_done_q;

    assign ZQCL  = (state_q == S_ZQ);
    assign MRS   = (state_q == S_MRS);
    assign REF   = (state_q == S_REF);
    assign PRE   = (state_q == S_PRE);
    assign ACT   = (state_q == S_ACT);
    assign READ  = (state_q == S_RW) && !wr_flag_q;
    assign WRITE = (state_q == S_RW) &&  wr_flag_q;
    assign A_10  = (state_q == S_PRE);

    assign Addr_Row    = addr_row_q;
    assign Addr_Column = addr_col_q;
    assign DQ_out      = wdata_q;
    assign init_done   = init_done_q;
    assign row_open    = row_open_q;
    assign open_row    = open_row_q;
endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
// Directed bench for ddr3_cmd_scheduler with default timing parameters.
// Cycle 0 is the first cycle with RESET low; outputs are sampled 1ns after
// each rising edge.
module tb_ddr3_cmd_scheduler;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        ZQCL, MRS, REF, PRE, ACT, READ, WRITE;
    logic [14:0] Addr_Row;
    logic [9:0]  Addr_Column;
    logic        A_10;
    logic [15:0] DQ_out;
    logic        init_done, row_open;
    logic [14:0] open_row;
    logic [6:0]  strobes;
    int          cyc;
    int          n_pass = 0;
    int          n_total = 0;

    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_ZQ   = 7'b1000000;
    localparam logic [6:0] S_MRS  = 7'b0100000;
    localparam logic [6:0] S_REF  = 7'b0010000;
    localparam logic [6:0] S_PRE  = 7'b0001000;
    localparam logic [6:0] S_ACT  = 7'b0000100;
    localparam logic [6:0] S_RD   = 7'b0000010;
    localparam logic [6:0] S_WR   = 7'b0000001;

    ddr3_cmd_scheduler_if host_if ();

    ddr3_cmd_scheduler dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .host        (host_if),
        .ZQCL        (ZQCL),
        .MRS         (MRS),
        .REF         (REF),
        .PRE         (PRE),
        .ACT         (ACT),
        .READ        (READ),
        .WRITE       (WRITE),
        .Addr_Row    (Addr_Row),
        .Addr_Column (Addr_Column),
        .A_10        (A_10),
        .DQ_out      (DQ_out),
        .init_done   (init_done),
        .row_open    (row_open),
        .open_row    (open_row)
    );

    assign strobes = {ZQCL, MRS, REF, PRE, ACT, READ, WRITE};

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Checks cycles 0..13 of the power-up sequence; ends in cycle 13.
    task automatic check_init_sequence(input string tag);
        logic [6:0] exp_s;
        logic       exp_b;
        for (int c = 0; c < 14; c++) begin
            exp_s = (c == 2) ? S_ZQ : ((c == 6) ? S_MRS : S_NONE);
            exp_b = (c >= 10);
            n_total++;
            if (strobes !== exp_s) $display("FAIL %s strobes cycle %0d: got %b expected %b", tag, c, strobes, exp_s);
            else n_pass++;
            n_total++;
            if (init_done !== exp_b) $display("FAIL %s init_done cycle %0d: got %b expected %b", tag, c, init_done, exp_b);
            else n_pass++;
            n_total++;
            if (host_if.req_ready !== exp_b) $display("FAIL %s req_ready cycle %0d: got %b expected %b", tag, c, host_if.req_ready, exp_b);
            else n_pass++;
            if (c < 13) step();
        end
    endtask

    task automatic send_req(input logic wr, input logic [14:0] row, input logic [9:0] col,
                            input logic [15:0] data, input string tag);
        int waited;
        host_if.req_write = wr;
        host_if.req_row   = row;
        host_if.req_col   = col;
        host_if.req_wdata = data;
        host_if.req_valid = 1'b1;
        waited = 0;
        while (host_if.req_ready !== 1'b1 && waited < 50) begin
            step();
            waited++;
        end
        n_total++;
        if (host_if.req_ready !== 1'b1) $display("FAIL %s accept: req_ready %b after %0d cycles, expected 1", tag, host_if.req_ready, waited);
        else n_pass++;
        $display("%s: %s row %0d col %0d data %0d accepted at cycle %0d", tag, wr ? "write" : "read", row, col, data, cyc);
        step();
        host_if.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        host_if.req_valid = 1'b0;
        host_if.req_write = 1'b0;
        host_if.req_row   = '0;
        host_if.req_col   = '0;
        host_if.req_wdata = '0;
        repeat (2) @(posedge CLK);
        #1;
        n_total++;
        if (strobes !== S_NONE) $display("FAIL reset strobes: got %b expected %b", strobes, S_NONE);
        else n_pass++;
        n_total++;
        if ({host_if.rsp_done, host_if.req_ready, init_done, row_open, A_10} !== 5'b0)
            $display("FAIL reset flags: got %b expected 00000", {host_if.rsp_done, host_if.req_ready, init_done, row_open, A_10});
        else n_pass++;
        n_total++;
        if ({Addr_Row, Addr_Column, DQ_out, open_row} !== 56'd0)
            $display("FAIL reset regs: got %h expected 0", {Addr_Row, Addr_Column, DQ_out, open_row});
        else n_pass++;
        RESET = 1'b0;
        check_init_sequence("init");
    endtask

    task automatic test_closed_write();
        logic [6:0] exp_s;
        send_req(1'b1, 15'd5, 10'd7, 16'd2025, "closed_write");
        for (int k = 1; k <= 8; k++) begin
            exp_s = (k == 1) ? S_ACT : ((k == 4) ? S_WR : S_NONE);
            n_total++;
            if (strobes !== exp_s) $display("FAIL closed_write strobes N+%0d: got %b expected %b", k, strobes, exp_s);
            else n_pass++;
            n_total++;
            if (host_if.rsp_done !== (k == 8)) $display("FAIL closed_write rsp_done N+%0d: got %b expected %b", k, host_if.rsp_done, (k == 8));
            else n_pass++;
            n_total++;
            if (row_open !== (k >= 2)) $display("FAIL closed_write row_open N+%0d: got %b expected %b", k, row_open, (k >= 2));
            else n_pass++;
            if (k == 1) begin
                n_total++;
                if (Addr_Row !== 15'd5) $display("FAIL closed_write Addr_Row: got %0d expected 5", Addr_Row);
                else n_pass++;
            end
            if (k == 4) begin
                n_total++;
                if (Addr_Column !== 10'd7) $display("FAIL closed_write Addr_Column: got %0d expected 7", Addr_Column);
                else n_pass++;
                n_total++;
                if (DQ_out !== 16'd2025) $display("FAIL closed_write DQ_out: got %0d expected 2025", DQ_out);
                else n_pass++;
            end
            if (k >= 2) begin
                n_total++;
                if (open_row !== 15'd5) $display("FAIL closed_write open_row N+%0d: got %0d expected 5", k, open_row);
                else n_pass++;
            end
            if (k == 8) begin
                n_total++;
                if (host_if.req_ready !== 1'b1) $display("FAIL closed_write req_ready after done: got %b expected 1", host_if.req_ready);
                else n_pass++;
            end
            if (k < 8) step();
        end
    endtask

    task automatic test_row_hit();
        logic [6:0] exp_s;
        send_req(1'b0, 15'd5, 10'd9, 16'd0, "row_hit");
        for (int k = 1; k <= 5; k++) begin
            exp_s = (k == 1) ? S_RD : S_NONE;
            n_total++;
            if (strobes !== exp_s) $display("FAIL row_hit strobes N+%0d: got %b expected %b", k, strobes, exp_s);
            else n_pass++;
            n_total++;
            if (host_if.rsp_done !== (k == 5)) $display("FAIL row_hit rsp_done N+%0d: got %b expected %b", k, host_if.rsp_done, (k == 5));
            else n_pass++;
            if (k == 1) begin
                n_total++;
                if ({A_10, Addr_Column} !== {1'b0, 10'd9}) $display("FAIL row_hit A_10/Addr_Column: got %b/%0d expected 0/9", A_10, Addr_Column);
                else n_pass++;
            end
            if (k < 5) step();
        end
    endtask

    task automatic test_row_miss();
        logic [6:0]  exp_s;
        logic [14:0] exp_row;
        send_req(1'b0, 15'd6, 10'd4, 16'd0, "row_miss");
        for (int k = 1; k <= 11; k++) begin
            exp_s   = (k == 1) ? S_PRE : ((k == 4) ? S_ACT : ((k == 7) ? S_RD : S_NONE));
            exp_row = (k >= 5) ? 15'd6 : 15'd5;
            n_total++;
            if (strobes !== exp_s) $display("FAIL row_miss strobes N+%0d: got %b expected %b", k, strobes, exp_s);
            else n_pass++;
            n_total++;
            if (A_10 !== (k == 1)) $display("FAIL row_miss A_10 N+%0d: got %b expected %b", k, A_10, (k == 1));
            else n_pass++;
            n_total++;
            if (open_row !== exp_row) $display("FAIL row_miss open_row N+%0d: got %0d expected %0d", k, open_row, exp_row);
            else n_pass++;
            n_total++;
            if (host_if.rsp_done !== (k == 11)) $display("FAIL row_miss rsp_done N+%0d: got %b expected %b", k, host_if.rsp_done, (k == 11));
            else n_pass++;
            if (k == 4) begin
                n_total++;
                if (Addr_Row !== 15'd6) $display("FAIL row_miss Addr_Row at ACT: got %0d expected 6", Addr_Row);
                else n_pass++;
            end
            if (k < 11) step();
        end
    endtask

    // First refresh becomes pending in cycle 210 with row 6 open.
    task automatic test_refresh_preempt();
        logic [6:0] exp_s;
        for (int i = 0; i < 400 && cyc < 210; i++) step();
        host_if.req_write = 1'b0;
        host_if.req_row   = 15'd6;
        host_if.req_col   = 10'd3;
        host_if.req_valid = 1'b1;
        $display("refresh_preempt: read row 6 col 3 presented at cycle %0d", cyc);
        for (int c = 210; c <= 232; c++) begin
            exp_s = (c == 211) ? S_PRE : (c == 214) ? S_REF : (c == 225) ? S_ACT : (c == 228) ? S_RD : S_NONE;
            n_total++;
            if (strobes !== exp_s) $display("FAIL refresh strobes cycle %0d: got %b expected %b", c, strobes, exp_s);
            else n_pass++;
            n_total++;
            if (host_if.req_ready !== (c == 224 || c == 232)) $display("FAIL refresh req_ready cycle %0d: got %b expected %b", c, host_if.req_ready, (c == 224 || c == 232));
            else n_pass++;
            n_total++;
            if (row_open !== (c <= 214 || c >= 226)) $display("FAIL refresh row_open cycle %0d: got %b expected %b", c, row_open, (c <= 214 || c >= 226));
            else n_pass++;
            n_total++;
            if (A_10 !== (c == 211)) $display("FAIL refresh A_10 cycle %0d: got %b expected %b", c, A_10, (c == 211));
            else n_pass++;
            n_total++;
            if (host_if.rsp_done !== (c == 232)) $display("FAIL refresh rsp_done cycle %0d: got %b expected %b", c, host_if.rsp_done, (c == 232));
            else n_pass++;
            if (c == 225) begin
                n_total++;
                if (Addr_Row !== 15'd6) $display("FAIL refresh Addr_Row at ACT: got %0d expected 6", Addr_Row);
                else n_pass++;
            end
            if (c < 232) step();
            if (c == 224) host_if.req_valid = 1'b0;
        end
    endtask

    // Second wrap lands on the same edge as a row-hit accept in cycle 409.
    task automatic test_back_to_back();
        logic [6:0] exp_s;
        for (int i = 0; i < 400 && cyc < 409; i++) step();
        host_if.req_write = 1'b0;
        host_if.req_row   = 15'd6;
        host_if.req_col   = 10'd1;
        host_if.req_valid = 1'b1;
        n_total++;
        if (host_if.req_ready !== 1'b1) $display("FAIL simultaneous req_ready cycle 409: got %b expected 1", host_if.req_ready);
        else n_pass++;
        $display("simultaneous: read row 6 col 1 presented at cycle %0d", cyc);
        step();
        host_if.req_valid = 1'b0;
        for (int c = 410; c <= 428; c++) begin
            exp_s = (c == 410) ? S_RD : (c == 415) ? S_PRE : (c == 418) ? S_REF : S_NONE;
            n_total++;
            if (strobes !== exp_s) $display("FAIL simultaneous strobes cycle %0d: got %b expected %b", c, strobes, exp_s);
            else n_pass++;
            n_total++;
            if (host_if.rsp_done !== (c == 414)) $display("FAIL simultaneous rsp_done cycle %0d: got %b expected %b", c, host_if.rsp_done, (c == 414));
            else n_pass++;
            n_total++;
            if (host_if.req_ready !== (c == 428)) $display("FAIL simultaneous req_ready cycle %0d: got %b expected %b", c, host_if.req_ready, (c == 428));
            else n_pass++;
            n_total++;
            if (row_open !== (c <= 418)) $display("FAIL simultaneous row_open cycle %0d: got %b expected %b", c, row_open, (c <= 418));
            else n_pass++;
            if (c < 428) step();
        end
    endtask

    task automatic test_reset_mid_op();
        send_req(1'b1, 15'd9, 10'd2, 16'hBEEF, "reset_mid");
        n_total++;
        if (strobes !== S_ACT) $display("FAIL reset_mid ACT: got %b expected %b", strobes, S_ACT);
        else n_pass++;
        step();
        RESET = 1'b1;
        step();
        n_total++;
        if (strobes !== S_NONE) $display("FAIL reset_mid strobes: got %b expected %b", strobes, S_NONE);
        else n_pass++;
        n_total++;
        if ({row_open, host_if.rsp_done, init_done, host_if.req_ready} !== 4'b0)
            $display("FAIL reset_mid flags: got %b expected 0000", {row_open, host_if.rsp_done, init_done, host_if.req_ready});
        else n_pass++;
        RESET = 1'b0;
        check_init_sequence("reinit");
    endtask

    initial begin
        test_reset();
        test_closed_write();
        test_row_hit();
        test_row_miss();
        test_refresh_preempt();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end
endmodule
